// File: rtl/tapped_delay_pkg.sv
// Shared defaults and width helpers for the tapped delay line.
package tapped_delay_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 32;
    localparam int DEF_NUM_TAPS  = 3;
    localparam int DEF_RST_DELAY = 1;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/tdl_tap_sel.sv
// One output tap: picks the history word for its delay and flags it valid once enough samples exist.
module tdl_tap_sel
    import tapped_delay_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int DW    = clog2_min1(DEF_DEPTH + 1)
) (
    input  logic [DW-1:0]          delay_i,
    input  logic [DW-1:0]          fill_i,
    input  logic [DEPTH*WIDTH-1:0] hist_i,
    output logic [WIDTH-1:0]       q_o,
    output logic                   valid_o
);

    always_comb begin
        // NOTE: default assigned first so no path through this block can leave q_o unassigned and infer a latch.
        q_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (delay_i == DW'(k + 1)) q_o = hist_i[k*WIDTH +: WIDTH];
        end
    end

    assign valid_o = (delay_i != '0) && (fill_i >= delay_i);

endmodule

// File: rtl/tapped_delay_line.sv
// Multi-tap delay line: shared shift history, saturating fill counter and per-tap programmable delays.
module tapped_delay_line
    import tapped_delay_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int NUM_TAPS  = DEF_NUM_TAPS,
    parameter  int RST_DELAY = DEF_RST_DELAY,
    localparam int TW        = clog2_min1(NUM_TAPS),
    localparam int DW        = clog2_min1(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH-1:0]          d,
    input  logic                      cfg_we,
    input  logic [TW-1:0]             cfg_tap,
    input  logic [DW-1:0]             cfg_delay,
    output logic                      cfg_err,
    output logic [NUM_TAPS*WIDTH-1:0] q,
    output logic [NUM_TAPS-1:0]       tap_valid,
    output logic [DW-1:0]             fill
);

    localparam logic [DW-1:0] DEPTH_W      = DW'(DEPTH);
    localparam logic [DW-1:0] RST_DELAY_W  = DW'(RST_DELAY);
    localparam logic [TW:0]   NUM_TAPS_W   = (TW + 1)'(NUM_TAPS);

    logic [DEPTH*WIDTH-1:0]       hist_q, hist_d;
    logic [DW-1:0]                fill_q, fill_d;
    logic [NUM_TAPS-1:0][DW-1:0]  delay_q, delay_d;
    logic                         cfg_err_q, cfg_err_d;
    logic                         cfg_ok;

    assign cfg_ok = ({1'b0, cfg_tap} < NUM_TAPS_W) && (cfg_delay <= DEPTH_W);

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        delay_d   = delay_q;
        cfg_err_d = cfg_we && !cfg_ok;
        if (en) begin
            // Word 0 (newest sample) sits in the least significant slot.
            hist_d = {hist_q[(DEPTH-1)*WIDTH-1:0], d};
            if (fill_q != DEPTH_W) fill_d = fill_q + DW'(1);
        end
        if (cfg_we && cfg_ok) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if ({1'b0, cfg_tap} == (TW + 1)'(i)) delay_d[i] = cfg_delay;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the history is reset explicitly because pre-fill taps must read back zeros.
            hist_q    <= '0;
            fill_q    <= '0;
            delay_q   <= {NUM_TAPS{RST_DELAY_W}};
            cfg_err_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            delay_q   <= delay_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
        tdl_tap_sel #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_tap_sel (
            .delay_i (delay_q[g]),
            .fill_i  (fill_q),
            .hist_i  (hist_q),
            .q_o     (q[g*WIDTH +: WIDTH]),
            .valid_o (tap_valid[g])
        );
    end

    assign cfg_err = cfg_err_q;
    assign fill    = fill_q;

endmodule

// File: tb/tb_tapped_delay_line.sv
// Randomised and directed bench for tapped_delay_line against a queue-based reference model.
module tb_tapped_delay_line;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 32;
    localparam int NUM_TAPS = 3;

    logic                      clk;
    logic                      rst;
    logic                      en;
    logic [WIDTH-1:0]          d;
    logic                      cfg_we;
    logic [1:0]                cfg_tap;
    logic [5:0]                cfg_delay;
    logic                      cfg_err;
    logic [NUM_TAPS*WIDTH-1:0] q;
    logic [NUM_TAPS-1:0]       tap_valid;
    logic [5:0]                fill;

    tapped_delay_line #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .NUM_TAPS  (NUM_TAPS),
        .RST_DELAY (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .d         (d),
        .cfg_we    (cfg_we),
        .cfg_tap   (cfg_tap),
        .cfg_delay (cfg_delay),
        .cfg_err   (cfg_err),
        .q         (q),
        .tap_valid (tap_valid),
        .fill      (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: enabled samples since reset, newest first.
    logic [WIDTH-1:0] hist_m[$];
    int               fill_m;
    int               dly_m[NUM_TAPS];
    bit               err_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            hist_m.delete();
            fill_m = 0;
            foreach (dly_m[i]) dly_m[i] = 1;
            err_m = 1'b0;
        end else begin
            err_m = 1'b0;
            if (cfg_we) begin
                if (cfg_tap < NUM_TAPS && cfg_delay <= DEPTH) dly_m[cfg_tap] = cfg_delay;
                else err_m = 1'b1;
            end
            if (en) begin
                hist_m.push_front(d);
                if (hist_m.size() > DEPTH) void'(hist_m.pop_back());
                fill_m = (fill_m + 1 > DEPTH) ? DEPTH : fill_m + 1;
            end
        end
    endtask

    task automatic check_all();
        logic [NUM_TAPS-1:0] v_exp;
        for (int i = 0; i < NUM_TAPS; i++) begin
            logic [WIDTH-1:0] q_exp;
            int n;
            n = dly_m[i];
            q_exp = (n != 0 && n <= hist_m.size()) ? hist_m[n-1] : '0;
            v_exp[i] = (n != 0) && (fill_m >= n);
            check($sformatf("q_tap%0d", i), 32'(q[i*WIDTH +: WIDTH]), 32'(q_exp));
        end
        check("tap_valid", 32'(tap_valid), 32'(v_exp));
        check("fill", 32'(fill), 32'(fill_m));
        check("cfg_err", 32'(cfg_err), 32'(err_m));
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        en  = 1'b0;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] tap, input logic [5:0] dly);
        cfg_we    = 1'b1;
        cfg_tap   = tap;
        cfg_delay = dly;
        tick();
        cfg_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; d = '0;
        cfg_we = 1'b0; cfg_tap = '0; cfg_delay = '0;

        // Reset defaults and first sample through delay-1 taps.
        do_reset(2);
        check("rst_valid", 32'(tap_valid), 32'h0);
        check("rst_fill", 32'(fill), 32'h0);
        en = 1'b1; d = 8'hA5;
        tick();
        check("first_q", 32'(q), 32'hA5A5A5);
        check("first_valid", 32'(tap_valid), 32'h7);
        check("first_fill", 32'(fill), 32'd1);
        d = 8'h00;
        tick();
        check("second_q", 32'(q), 32'h0);

        // Delays 1/23/23 with a counting stream.
        do_reset(1);
        cfg_write(2'd1, 6'd23);
        cfg_write(2'd2, 6'd23);
        en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            d = WIDTH'(k);
            tick();
            if (k == 21) check("valid_pre23", 32'(tap_valid), 32'h1);
            if (k == 22) check("valid_at23", 32'(tap_valid), 32'h7);
            if (k >= 22) check("tap1_lag", 32'(q[15:8]), 32'(k - 22));
        end

        // Enable gating: only enabled edges advance history and fill.
        do_reset(1);
        cfg_write(2'd1, 6'd2);
        cfg_write(2'd2, 6'd3);
        for (int i = 0; i < 16; i++) begin
            d  = WIDTH'(8'h10 + i);
            en = (i % 2 == 0);
            tick();
        end
        check("gate_fill", 32'(fill), 32'd8);
        en = 1'b0;

        // Rejected writes, then disabling a tap.
        cfg_write(2'd3, 6'd5);
        check("err_bad_tap", 32'(cfg_err), 32'h1);
        cfg_write(2'd0, 6'd33);
        check("err_bad_delay", 32'(cfg_err), 32'h1);
        tick();
        check("err_cleared", 32'(cfg_err), 32'h0);
        cfg_write(2'd2, 6'd0);
        check("tap2_off_q", 32'(q[23:16]), 32'h0);
        check("tap2_off_v", 32'(tap_valid[2]), 32'h0);
        check("tap2_off_err", 32'(cfg_err), 32'h0);

        // Fill saturation and reconfiguration to the maximum delay.
        do_reset(1);
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = WIDTH'(8'h40 + i);
            tick();
        end
        en = 1'b0;
        check("sat_fill", 32'(fill), 32'd32);
        cfg_write(2'd0, 6'd32);
        check("sat_q0", 32'(q[7:0]), 32'h48);
        check("sat_v0", 32'(tap_valid[0]), 32'h1);

        // Reset wins over a simultaneous write and shift.
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = WIDTH'($urandom);
            tick();
        end
        rst = 1'b1; cfg_we = 1'b1; cfg_tap = 2'd0; cfg_delay = 6'd5; d = 8'hFF;
        tick();
        rst = 1'b0; cfg_we = 1'b0; en = 1'b0;
        check("mid_rst_fill", 32'(fill), 32'h0);
        check("mid_rst_q", 32'(q), 32'h0);
        check("mid_rst_err", 32'(cfg_err), 32'h0);
        tick();
        check("mid_rst_delay", 32'(tap_valid), 32'h0);

        // Random traffic with occasional writes (some invalid) and resets.
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            en        = ($urandom_range(0, 3) != 0);
            d         = WIDTH'($urandom);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_tap   = 2'($urandom_range(0, 3));
            cfg_delay = 6'($urandom_range(0, 36));
            tick();
        end
        rst = 1'b0; cfg_we = 1'b0; en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
